// File: rtl/imem_pkg.sv
// Shared definitions for the clocked instruction memory fetch unit.
// State encoding, fault bit positions and the default faulted-fetch word.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int FLT_MISALIGN = 0;
   localparam int FLT_RANGE    = 1;

   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_byte_array.sv
// Byte storage with a 4-lane byte-enable word write and a
// 4-byte big-endian combinational read at any byte address.
module imem_byte_array #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_BYTES = 512
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);

   logic [7:0]        mem [DEPTH_BYTES];
   logic [ADDR_W-1:0] wa  [4];
   logic [ADDR_W-1:0] ra  [4];

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         wa[k] = waddr + ADDR_W'(k);
         ra[k] = raddr + ADDR_W'(k);
      end
   end

   // Lane k is byte address +k and carries bits [31-8k -: 8].
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[3-k] && (wa[k] < DEPTH_A)) begin
               mem[wa[k][IW-1:0]] <= wdata[8*(3-k) +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < 4; k++) begin
         if (ra[k] < DEPTH_A) begin
            rdata[8*(3-k) +: 8] = mem[ra[k][IW-1:0]];
         end
      end
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// Clocked instruction memory: boot load port, LOAD/RUN/DRAIN mode
// control, one-cycle fetch with held outputs and fault reporting.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          DEPTH_BYTES = 512,
   parameter logic [31:0] NOP_WORD    = DEF_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   input  logic [3:0]        ld_be,
   output logic              ld_ready,
   output logic              ld_err,
   input  logic              ld_done,
   input  logic              reload,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              req_ready,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [1:0]        fault,
   output logic [1:0]        mode
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] ld_wa;
   logic              ld_oor;
   logic              ld_fire;
   logic              req_fire;
   logic [1:0]        flt;
   logic [31:0]       rdata;

   assign ld_wa    = ld_addr & ~ADDR_W'(3);
   assign ld_oor   = ld_wa > LAST_WORD;
   assign ld_ready = (state_q == ST_LOAD);
   assign ld_fire  = ld_valid && ld_ready;

   // A same-cycle reload wins over the fetch request.
   assign req_ready = (state_q == ST_RUN) && !reload;
   assign req_fire  = req_valid && req_ready;

   assign mode = state_q;

   always_comb begin
      flt               = '0;
      flt[FLT_MISALIGN] = |req_pc[1:0];
      flt[FLT_RANGE]    = req_pc > LAST_WORD;
   end

   imem_byte_array #(
      .ADDR_W      (ADDR_W),
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_mem (
      .clk   (clk),
      .we    (ld_fire && !ld_oor),
      .waddr (ld_wa),
      .wdata (ld_data),
      .be    (ld_be),
      .raddr (req_pc),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD:  if (ld_done) state_d = ST_RUN;
         ST_RUN:   if (reload) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_LOAD;
         default:  state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_err     <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         fault      <= '0;
      end else begin
         ld_err <= ld_fire && ld_oor;
         if (req_fire) begin
            inst_valid <= 1'b1;
            inst_pc    <= req_pc;
            fault      <= flt;
            inst       <= (|flt) ? NOP_WORD : rdata;
         end else if ((state_q == ST_RUN) && reload) begin
            inst_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit.
module tb_imem_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;
   logic        ld_ready;
   logic        ld_err;
   logic        ld_done;
   logic        reload;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        req_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  fault;
   logic [1:0]  mode;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imem_fetch_unit #(
      .ADDR_W      (32),
      .DEPTH_BYTES (512),
      .NOP_WORD    (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_be      (ld_be),
      .ld_ready   (ld_ready),
      .ld_err     (ld_err),
      .ld_done    (ld_done),
      .reload     (reload),
      .req_valid  (req_valid),
      .req_pc     (req_pc),
      .req_ready  (req_ready),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .fault      (fault),
      .mode       (mode)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic done);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      ld_be    = be;
      ld_done  = done;
      tick();
      ld_valid = 1'b0;
      ld_done  = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] pc);
      req_valid = 1'b1;
      req_pc    = pc;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_be = 0;
      ld_done = 0; reload = 0; req_valid = 0; req_pc = 0;
      #3;
      n_checks++; if (mode !== 2'd0) begin n_fail++; $display("FAIL rst_mode got %0d want 0", mode); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid); end
      n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", inst); end
      n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", inst_pc); end
      n_checks++; if (fault !== 2'b00) begin n_fail++; $display("FAIL rst_fault got %b want 00", fault); end
      n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL rst_lderr got %b want 0", ld_err); end
      n_checks++; if ({ld_ready, req_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_ready got %b want 10", {ld_ready, req_ready}); end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_run();
      do_load(32'd0,   32'h8C22_0004, 4'hF, 1'b0);
      do_load(32'd4,   32'h0000_0000, 4'hF, 1'b0);
      do_load(32'd4,   32'hAABB_CCDD, 4'b1010, 1'b0);
      do_load(32'd508, 32'h1122_3344, 4'hF, 1'b1);
      n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL run_mode got %0d want 1", mode); end
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_ldready got %b want 0", ld_ready); end
      req_valid = 1'b1; req_pc = 0; #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL run_reqready got %b want 1", req_ready); end
      do_fetch(32'd0);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL f0_valid got %b want 1", inst_valid); end
      n_checks++; if (inst !== 32'h8C22_0004) begin n_fail++; $display("FAIL f0_inst got %h want 8c220004", inst); end
      n_checks++; if (fault !== 2'b00) begin n_fail++; $display("FAIL f0_fault got %b want 00", fault); end
      do_fetch(32'd4);
      n_checks++; if (inst !== 32'hAA00_CC00) begin n_fail++; $display("FAIL f4_be_inst got %h want aa00cc00", inst); end
      n_checks++; if (inst_pc !== 32'd4) begin n_fail++; $display("FAIL f4_pc got %h want 4", inst_pc); end
      do_fetch(32'd508);
      n_checks++; if ({fault, inst} !== {2'b00, 32'h1122_3344}) begin n_fail++; $display("FAIL f508 got %b/%h want 00/11223344", fault, inst); end
      tick();
      tick();
      n_checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h1122_3344, 32'd508}) begin n_fail++; $display("FAIL hold got %b/%h/%h want 1/11223344/1fc", inst_valid, inst, inst_pc); end
   endtask

   task automatic test_faults();
      do_fetch(32'd2);
      n_checks++; if ({fault, inst} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL mis got %b/%h want 01/0", fault, inst); end
      do_fetch(32'd512);
      n_checks++; if ({fault, inst, inst_pc} !== {2'b10, 32'h0, 32'd512}) begin n_fail++; $display("FAIL oor got %b/%h/%h want 10/0/200", fault, inst, inst_pc); end
      do_fetch(32'hFFFF_FFFE);
      n_checks++; if ({inst_valid, fault, inst} !== {1'b1, 2'b11, 32'h0}) begin n_fail++; $display("FAIL both got %b/%b/%h want 1/11/0", inst_valid, fault, inst); end
   endtask

   task automatic test_reload();
      reload = 1'b1; req_valid = 1'b1; req_pc = 32'd0; #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rl_reqready got %b want 0", req_ready); end
      tick();
      reload = 1'b0; req_valid = 1'b0;
      n_checks++; if ({mode, inst_valid} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL drain got %0d/%b want 2/0", mode, inst_valid); end
      n_checks++; if ({ld_ready, req_ready} !== 2'b00) begin n_fail++; $display("FAIL drain_ready got %b want 00", {ld_ready, req_ready}); end
      n_checks++; if (inst_pc !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rl_noaccept got %h want fffffffe", inst_pc); end
      tick();
      n_checks++; if ({mode, ld_ready} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL post_drain got %0d/%b want 0/1", mode, ld_ready); end
   endtask

   task automatic test_load_err();
      do_load(32'd512, 32'hDEAD_BEEF, 4'hF, 1'b0);
      n_checks++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL lderr_hi got %b want 1", ld_err); end
      tick();
      n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL lderr_lo got %b want 0", ld_err); end
      do_load(32'd508, 32'h5566_7788, 4'h0, 1'b0);
      n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL lderr_edge got %b want 0", ld_err); end
      req_valid = 1'b1; req_pc = 32'd0; #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_reqready got %b want 0", req_ready); end
      tick();
      req_valid = 1'b0;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL load_novalid got %b want 0", inst_valid); end
   endtask

   task automatic test_reset_mid_run();
      ld_done = 1'b1; tick(); ld_done = 1'b0;
      do_fetch(32'd0);
      n_checks++; if ({inst_valid, inst} !== {1'b1, 32'h8C22_0004}) begin n_fail++; $display("FAIL pre_rst got %b/%h want 1/8c220004", inst_valid, inst); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({inst_valid, mode} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL async_rst got %b/%0d want 0/0", inst_valid, mode); end
      tick();
      rst_n = 1'b1;
      tick();
      ld_done = 1'b1; tick(); ld_done = 1'b0;
      do_fetch(32'd4);
      n_checks++; if (inst !== 32'hAA00_CC00) begin n_fail++; $display("FAIL kept4 got %h want aa00cc00", inst); end
      do_fetch(32'd508);
      n_checks++; if (inst !== 32'h1122_3344) begin n_fail++; $display("FAIL kept508 got %h want 11223344", inst); end
      do_fetch(32'd0);
      n_checks++; if (inst !== 32'h8C22_0004) begin n_fail++; $display("FAIL kept0 got %h want 8c220004", inst); end
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_faults();
      test_reload();
      test_load_err();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
